// File: rtl/lunar_thrust_ctrl.sv
// Thrust sequencer for the Lunar Lander core: arbitrates analog stick vs D-pad ramp,
// slews bumplessly on source changes, saturates at THRUST_MAX and supports a forced-zero hold.
module lunar_thrust_ctrl #(
    parameter int unsigned TICK_DIV   = 98425,
    parameter int unsigned THRUST_MAX = 254,
    parameter int unsigned SLEW_STEP  = 4
) (
    input  logic       clk_25,
    input  logic       RESET_L,
    input  logic       src_sel,
    input  logic [7:0] analog_y,
    input  logic       dpad_up,
    input  logic       dpad_down,
    input  logic       force_zero,
    output logic [7:0] thrust,
    output logic       thrust_chg,
    output logic       slewing
);

    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0]  TMAX = 8'(THRUST_MAX);
    localparam logic [7:0]  STEP = 8'(SLEW_STEP);

    typedef enum logic [1:0] {SLEW, TRACK_A, TRACK_D} state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    dpad_acc, acc_next;
    logic [7:0]    thrust_next;
    logic [8:0]    a_raw;
    logic [7:0]    a_tgt;
    logic [7:0]    slew_val;

    assign tick = (presc == PW'(TICK_DIV - 1));

    // 127 - y in 9 bits spans 0..255 exactly, so the modular result needs no sign handling
    assign a_raw = 9'd127 - {analog_y[7], analog_y};
    assign a_tgt = (a_raw > {1'b0, TMAX}) ? TMAX : a_raw[7:0];

    always_comb begin
        slew_val = a_tgt;
        if (a_tgt > thrust) begin
            if ((a_tgt - thrust) > STEP)
                slew_val = thrust + STEP;
        end else if ((thrust - a_tgt) > STEP) begin
            slew_val = thrust - STEP;
        end
    end

    always_comb begin
        state_next  = state;
        thrust_next = thrust;
        acc_next    = dpad_acc;
        if (force_zero) begin
            thrust_next = '0;
            acc_next    = '0;
            state_next  = src_sel ? TRACK_D : SLEW;
        end else begin
            unique case (state)
                SLEW: begin
                    if (src_sel) begin
                        state_next = TRACK_D;
                        acc_next   = thrust;
                    end else begin
                        if (tick)
                            thrust_next = slew_val;
                        if (thrust == a_tgt)
                            state_next = TRACK_A;
                    end
                end
                TRACK_A: begin
                    if (src_sel) begin
                        state_next = TRACK_D;
                        acc_next   = thrust;
                    end else begin
                        thrust_next = a_tgt;
                    end
                end
                TRACK_D: begin
                    if (!src_sel) begin
                        state_next = SLEW;
                    end else begin
                        // thrust follows the previous accumulator value, one cycle behind
                        thrust_next = dpad_acc;
                        if (tick) begin
                            if (dpad_up && !dpad_down && dpad_acc < TMAX)
                                acc_next = dpad_acc + 8'd1;
                            else if (dpad_down && !dpad_up && dpad_acc != 8'd0)
                                acc_next = dpad_acc - 8'd1;
                        end
                    end
                end
                default: state_next = SLEW;
            endcase
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            presc      <= '0;
            state      <= SLEW;
            thrust     <= '0;
            dpad_acc   <= '0;
            thrust_chg <= 1'b0;
            slewing    <= 1'b1;
        end else begin
            presc      <= tick ? '0 : presc + PW'(1);
            state      <= state_next;
            thrust     <= thrust_next;
            dpad_acc   <= acc_next;
            thrust_chg <= (thrust_next != thrust);
            slewing    <= (state_next == SLEW);
        end
    end

endmodule
